// File: rtl/exe_muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide unit: widths, funct3 codes,
// FSM state encoding and the ALUOp value that routes an instruction to it.
package exe_muldiv_pkg;

  localparam int MD_XLEN  = 32;
  localparam int MD_CNT_W = 6;

  // Extends the existing ALUOp bus constants.
  localparam int               ALUOP_W      = 4;
  localparam logic [ALUOP_W-1:0] ALUOP_MULDIV = 4'd10;

  localparam logic [2:0] MULDIV_MUL    = 3'b000;
  localparam logic [2:0] MULDIV_MULH   = 3'b001;
  localparam logic [2:0] MULDIV_MULHSU = 3'b010;
  localparam logic [2:0] MULDIV_MULHU  = 3'b011;
  localparam logic [2:0] MULDIV_DIV    = 3'b100;
  localparam logic [2:0] MULDIV_DIVU   = 3'b101;
  localparam logic [2:0] MULDIV_REM    = 3'b110;
  localparam logic [2:0] MULDIV_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } muldiv_state_e;

  function automatic logic rs1_signed(input logic [2:0] op);
    return (op == MULDIV_MUL) || (op == MULDIV_MULH) || (op == MULDIV_MULHSU) ||
           (op == MULDIV_DIV) || (op == MULDIV_REM);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] op);
    return (op == MULDIV_MUL) || (op == MULDIV_MULH) ||
           (op == MULDIV_DIV) || (op == MULDIV_REM);
  endfunction

endpackage

// File: rtl/exe_muldiv_if.sv
// EXE-stage request/response bundle between the ID/EXE register and the muldiv unit.
interface exe_muldiv_if #(parameter int XLEN = exe_muldiv_pkg::MD_XLEN);

  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;
  logic [4:0]      rd_addr_i;
  logic            flush_i;
  logic            stall_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_addr_o;

  modport slave (
    input  start_i, op_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
    output stall_o, done_o, result_o, rd_addr_o
  );

  modport master (
    output start_i, op_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
    input  stall_o, done_o, result_o, rd_addr_o
  );

endinterface

// File: rtl/muldiv_sign_fix.sv
// Combinational FIXUP: restores signs on the magnitude result and picks the
// low/high product word, quotient or remainder.
module muldiv_sign_fix
  import exe_muldiv_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic [2:0]        op_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic              neg_res_i,
  input  logic              neg_rem_i,
  output logic [XLEN-1:0]   result_o
);

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  // Divide leaves the remainder in the upper half and the quotient in the lower.
  assign prod = neg_res_i ? -acc_i : acc_i;
  assign quo  = neg_res_i ? -acc_i[XLEN-1:0] : acc_i[XLEN-1:0];
  assign rem  = neg_rem_i ? -acc_i[2*XLEN-1:XLEN] : acc_i[2*XLEN-1:XLEN];

  always_comb begin
    result_o = prod[XLEN-1:0];
    case (op_i)
      MULDIV_MUL:                              result_o = prod[XLEN-1:0];
      MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: result_o = prod[2*XLEN-1:XLEN];
      MULDIV_DIV, MULDIV_DIVU:                 result_o = quo;
      MULDIV_REM, MULDIV_REMU:                 result_o = rem;
      default:                                 result_o = prod[XLEN-1:0];
    endcase
  end

endmodule

// File: rtl/exe_muldiv.sv
// Iterative RV32M multiply/divide, one bit per cycle; done_o XLEN+2 cycles after
// acceptance (1 for divide-by-zero/overflow). Holds the pipeline via stall_o while busy.
module exe_muldiv
  import exe_muldiv_pkg::*;
#(
  parameter int XLEN  = MD_XLEN,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  exe_muldiv_if.slave  mdif
);

  muldiv_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [4:0]        rd_out_q, rd_out_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;

  logic              s1, s2, is_div, div_zero, div_ovf;
  logic [XLEN-1:0]   mag1, mag2, fix_result;
  logic [XLEN:0]     mul_sum, div_trial, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next;

  assign s1       = rs1_signed(mdif.op_i) & mdif.rs1_data_i[XLEN-1];
  assign s2       = rs2_signed(mdif.op_i) & mdif.rs2_data_i[XLEN-1];
  assign mag1     = s1 ? -mdif.rs1_data_i : mdif.rs1_data_i;
  assign mag2     = s2 ? -mdif.rs2_data_i : mdif.rs2_data_i;
  assign is_div   = mdif.op_i[2];
  assign div_zero = (mdif.rs2_data_i == '0);
  assign div_ovf  = is_div && !mdif.op_i[0] &&
                    (mdif.rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (mdif.rs2_data_i == '1);

  // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Restoring divide: partial remainder (upper) shifts in dividend bits, quotient fills the low end.
  assign div_trial = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff  = div_trial - {1'b0, opnd_q};
  assign div_next  = div_diff[XLEN] ? {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .op_i      (op_q),
    .acc_i     (acc_q),
    .neg_res_i (neg_res_q),
    .neg_rem_i (neg_rem_q),
    .result_o  (fix_result)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rd_out_d  = rd_out_q;
    opnd_d    = opnd_q;
    result_d  = result_q;
    acc_d     = acc_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    case (state_q)
      ST_IDLE: begin
        if (mdif.start_i) begin
          op_d      = mdif.op_i;
          rd_d      = mdif.rd_addr_i;
          neg_res_d = s1 ^ s2;
          neg_rem_d = s1;
          cnt_d     = '0;
          if (is_div && div_zero) begin
            result_d = mdif.op_i[1] ? mdif.rs1_data_i : '1;
            rd_out_d = mdif.rd_addr_i;
            state_d  = ST_DONE;
          end else if (div_ovf) begin
            result_d = mdif.op_i[1] ? '0 : mdif.rs1_data_i;
            rd_out_d = mdif.rd_addr_i;
            state_d  = ST_DONE;
          end else begin
            opnd_d  = is_div ? mag2 : mag1;
            acc_d   = {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN-1)) state_d = ST_FIXUP;
      end
      ST_FIXUP: begin
        result_d = fix_result;
        rd_out_d = rd_q;
        state_d  = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // A killed instruction leaves the visible result untouched.
    if (mdif.flush_i) begin
      state_d  = ST_IDLE;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      rd_out_q  <= '0;
      opnd_q    <= '0;
      result_q  <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      rd_out_q  <= rd_out_d;
      opnd_q    <= opnd_d;
      result_q  <= result_d;
      acc_q     <= acc_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  // Combinational so ID/EXE holds on the acceptance cycle; low in DONE so the pipe advances.
  assign mdif.stall_o = rst_i && !mdif.flush_i &&
                        (((state_q == ST_IDLE) && mdif.start_i) ||
                         (state_q == ST_CALC) || (state_q == ST_FIXUP));
  assign mdif.done_o    = rst_i && !mdif.flush_i && (state_q == ST_DONE);
  assign mdif.result_o  = result_q;
  assign mdif.rd_addr_o = rd_out_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// Randomised and directed bench for exe_muldiv against a plain-arithmetic RV32M model.
module tb_exe_muldiv;
  import exe_muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_fail = 0;
  int cyc_now = 0;
  int last_done_cyc = 0;
  logic [31:0] last_exp = '0;
  logic [4:0]  last_rd = '0;

  exe_muldiv_if #(.XLEN(MD_XLEN)) mif ();

  exe_muldiv #(.XLEN(MD_XLEN), .CNT_W(MD_CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .mdif  (mif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_now <= cyc_now + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    logic signed [31:0] ssa, ssb;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    ssa = a;
    ssb = b;
    case (op)
      MULDIV_MUL:    begin p = sa * sb;           return p[31:0];  end
      MULDIV_MULH:   begin p = sa * sb;           return p[63:32]; end
      MULDIV_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      MULDIV_MULHU:  begin p = ua * ub;           return p[63:32]; end
      MULDIV_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ssa / ssb;
      end
      MULDIV_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MULDIV_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ssa % ssb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    if (!op[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // Presents one instruction, holds it like a stalled ID/EXE would, and checks through done_o.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input string tag);
    int cyc;
    int exp_lat;
    logic [31:0] exp_r;
    exp_r   = ref_md(op, a, b);
    exp_lat = is_special(op, a, b) ? 1 : 34;
    @(negedge clk);
    mif.start_i    = 1'b1;
    mif.op_i       = op;
    mif.rs1_data_i = a;
    mif.rs2_data_i = b;
    mif.rd_addr_i  = rd;
    mif.flush_i    = 1'b0;
    #1;
    check({tag, " stall_c0"}, 32'(mif.stall_o), 32'd1);
    check({tag, " done_c0"}, 32'(mif.done_o), 32'd0);
    cyc = 0;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      mif.rs1_data_i = $urandom();
      mif.rs2_data_i = $urandom();
      mif.rd_addr_i  = 5'($urandom_range(0, 31));
      #1;
      if (mif.done_o === 1'b1) break;
      check({tag, " stall_busy"}, 32'(mif.stall_o), 32'd1);
    end
    last_done_cyc = cyc_now;
    check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, " result"}, mif.result_o, exp_r);
    check({tag, " rd"}, 32'(mif.rd_addr_o), 32'(rd));
    check({tag, " stall_done"}, 32'(mif.stall_o), 32'd0);
    last_exp = exp_r;
    last_rd  = rd;
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    mif.start_i = 1'b0;
    mif.flush_i = 1'b0;
    #1;
    check({tag, " done_idle"}, 32'(mif.done_o), 32'd0);
    check({tag, " stall_idle"}, 32'(mif.stall_o), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t1;
    logic [2:0] rop;
    logic [31:0] ra, rb;
    logic [31:0] corners [6];
    corners[0] = 32'h8000_0000; corners[1] = 32'hFFFF_FFFF; corners[2] = 32'h0;
    corners[3] = 32'h7FFF_FFFF; corners[4] = 32'h1;         corners[5] = 32'hFFFF_FFFE;

    mif.start_i = 1'b1; mif.op_i = MULDIV_MUL; mif.rs1_data_i = 32'd3;
    mif.rs2_data_i = 32'd4; mif.rd_addr_i = 5'd7; mif.flush_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset stall", 32'(mif.stall_o), 32'd0);
    check("reset done", 32'(mif.done_o), 32'd0);
    check("reset result", mif.result_o, 32'd0);
    check("reset rd", 32'(mif.rd_addr_o), 32'd0);
    mif.start_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run_op(MULDIV_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  "mul");    idle_cycle("mul");
    run_op(MULDIV_MULH,   32'h8000_0000, 32'hFFFF_FFFF, 5'd6,  "mulh");   idle_cycle("mulh");
    run_op(MULDIV_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7,  "mulhsu"); idle_cycle("mulhsu");
    run_op(MULDIV_MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  "mulhu");  idle_cycle("mulhu");
    run_op(MULDIV_DIV,    32'hFFFF_FFF9, 32'd2,         5'd9,  "div");    idle_cycle("div");
    run_op(MULDIV_REM,    32'hFFFF_FFF9, 32'd2,         5'd10, "rem");    idle_cycle("rem");
    run_op(MULDIV_DIVU,   32'd100,       32'd7,         5'd11, "divu");   idle_cycle("divu");
    run_op(MULDIV_REMU,   32'd100,       32'd7,         5'd12, "remu");   idle_cycle("remu");
    run_op(MULDIV_DIV,    32'h1234_5678, 32'd0,         5'd13, "div0");   idle_cycle("div0");
    run_op(MULDIV_REMU,   32'd5,         32'd0,         5'd14, "remu0");  idle_cycle("remu0");
    run_op(MULDIV_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd15, "divovf"); idle_cycle("divovf");
    run_op(MULDIV_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd16, "removf"); idle_cycle("removf");
    run_op(MULDIV_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 5'd17, "divubig"); idle_cycle("divubig");

    run_op(MULDIV_MUL, 32'd123, 32'd456, 5'd3, "b2b_a");
    t1 = last_done_cyc;
    run_op(MULDIV_MUL, 32'hFFFF_FF00, 32'd77, 5'd9, "b2b_b");
    check("b2b spacing", 32'(last_done_cyc - t1), 32'd35);
    idle_cycle("b2b");

    // Kill a divide mid-flight.
    @(negedge clk);
    mif.start_i = 1'b1; mif.op_i = MULDIV_DIV; mif.rs1_data_i = 32'd1000;
    mif.rs2_data_i = 32'd3; mif.rd_addr_i = 5'd21;
    repeat (10) @(negedge clk);
    mif.flush_i = 1'b1;
    #1;
    check("flush stall", 32'(mif.stall_o), 32'd0);
    check("flush done", 32'(mif.done_o), 32'd0);
    @(negedge clk);
    mif.flush_i = 1'b0; mif.start_i = 1'b0;
    #1;
    check("flush done_next", 32'(mif.done_o), 32'd0);
    check("flush stall_next", 32'(mif.stall_o), 32'd0);
    check("flush result_kept", mif.result_o, last_exp);
    check("flush rd_kept", 32'(mif.rd_addr_o), 32'(last_rd));
    repeat (40) begin
      @(negedge clk);
      #1;
      check("flush no_done", 32'(mif.done_o), 32'd0);
    end
    run_op(MULDIV_DIV, 32'd1000, 32'd3, 5'd22, "post_flush"); idle_cycle("post_flush");

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    mif.start_i = 1'b1; mif.op_i = MULDIV_MUL; mif.rs1_data_i = 32'd9;
    mif.rs2_data_i = 32'd9; mif.rd_addr_i = 5'd30;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst stall", 32'(mif.stall_o), 32'd0);
    check("midrst done", 32'(mif.done_o), 32'd0);
    check("midrst result", mif.result_o, 32'd0);
    check("midrst rd", 32'(mif.rd_addr_o), 32'd0);
    @(negedge clk);
    mif.start_i = 1'b0;
    rst_n = 1'b1;
    run_op(MULDIV_MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd31, "post_rst"); idle_cycle("post_rst");

    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom();
      rb  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom();
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      run_op(rop, ra, rb, 5'($urandom_range(0, 31)), "rand");
      idle_cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_muldiv.md
Name: exe_muldiv

Overview:
Multi-cycle RV32M multiply/divide unit in the EXE stage. It consumes the operands, destination register and operation code latched by the ID/EXE pipeline register. It computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU iteratively, one bit per cycle. While it works, it raises a stall that freezes PC, IF/ID and ID/EXE, then hands a result and rd to the EXE/MEM register.

Parameters:
XLEN, 32, operand/result width in bits; the iteration count equals XLEN.
CNT_W, 6, iteration counter width; must be at least clog2(XLEN)+1.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low (0 = reset)
start_i  in  1  an M-extension instruction is valid in EXE (ALUOp decodes to muldiv)
op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_data_i  in  XLEN  operand A (after forwarding)
rs2_data_i  in  XLEN  operand B (after forwarding)
rd_addr_i  in  5  destination register
flush_i  in  1  branch/exception kill of the EXE instruction
stall_o  out  1  freeze upstream pipeline registers
done_o  out  1  one-cycle pulse: result_o/rd_addr_o valid, write-back enable
result_o  out  XLEN  result
rd_addr_o  out  5  destination register of result_o

Behaviour:
- States: IDLE, CALC, FIXUP, DONE.
- Reset (rst_i=0, any time, including mid-operation): state=IDLE, counter=0, result_o=0, rd_addr_o=0, done_o=0. stall_o=0 while in reset.
- IDLE, start_i=1, flush_i=0: at the edge, latch op, rd and operand magnitudes plus sign flags.
  - Signed operands are MUL* by op; DIV and REM are signed; MULHSU treats rs1 as signed and rs2 as unsigned.
- Special cases detected in IDLE go straight to DONE (done_o one cycle after the sampling edge):
  - divisor==0: DIV/DIVU return all ones; REM/REMU return rs1.
  - DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: DIV returns 0x80000000; REM returns 0.
  - Otherwise enter CALC with counter=0.
- CALC, multiply: shift-add into a 2*XLEN accumulator, one bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle on magnitudes.
- CALC length: after XLEN edges go to FIXUP.
- FIXUP (1 cycle): apply sign correction.
  - Product is negated when its signs differ.
  - Quotient is negated when signs differ; remainder takes the sign of the dividend.
  - Select the low word (MUL) or high word (MULH*); register result_o. Next edge: DONE.
- Normal latency: done_o is high in the cycle XLEN+2 edges after the sampling edge (34 for XLEN=32).
- DONE: done_o=1 for exactly one cycle. Next edge: IDLE unconditionally. start_i seen in DONE is ignored (it is the same instruction still held in ID/EXE).
- stall_o = (state==IDLE && start_i && !flush_i) || state==CALC || state==FIXUP. It is combinational so ID/EXE holds on the first cycle. It is low in DONE so the pipeline advances on the DONE edge.
- Back-to-back muldiv instructions: the second one is seen in IDLE the cycle after DONE and is accepted normally.
- flush_i=1 in any state: next edge goes to IDLE with no done_o pulse. stall_o is forced low that cycle. result_o keeps its old value.
- result_o and rd_addr_o hold their value until the next FIXUP or special-case completion.
- Operand inputs are sampled only in IDLE; changes during CALC have no effect.

Decomposition:
- Shared package/define file: XLEN, the MULDIV_* funct3 encodings, state encodings (2-bit), and the ALUOp value selecting muldiv. These extend the existing ALUOp bus constants.
- One sub-module is natural: muldiv_sign_fix, the combinational FIXUP negation and word/quotient/remainder select. The FSM, counter and datapath stay in exe_muldiv.

Test Plan:
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD) -> done_o at cycle 34, result 0xFFFFFFEB, stall_o high for cycles 0-33, rd echoed.
- MULH, MULHSU, MULHU with 0x80000000 x 0xFFFFFFFF:
  - MULH -> 0x00000000
  - MULHSU -> 0x80000000
  - MULHU -> 0x7FFFFFFF
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases, each with done_o one cycle after start and stall_o high only in the start cycle:
  - DIV x/0 -> 0xFFFFFFFF
  - REMU 5/0 -> 5
  - DIV 0x80000000/-1 -> 0x80000000
- flush_i at cycle 10 of a DIV -> IDLE next edge, no done_o, result_o unchanged. rst_i low at cycle 20 of a MUL -> all outputs 0 immediately.
- Two consecutive MULs (second presented after DONE) -> two done_o pulses 35 cycles apart with correct results and rd values.
